// File: rtl/flag_goal_if.sv
// Bundle between the flag stage / player sprite / game controller and flag_goal.
// master drives the scene inputs and acknowledge; slave is the goal sequencer.
interface flag_goal_if;
    logic       frame_clk;
    logic [9:0] FlagX;
    logic [9:0] FlagY;
    logic [9:0] FlagWidth;
    logic [9:0] FlagHeight;
    logic [9:0] PlayerX;
    logic [9:0] PlayerY;
    logic [9:0] PlayerS;
    logic       Level_Ack;
    logic [9:0] FlagDropY;
    logic       Freeze;
    logic       Level_Done;
    logic [3:0] Bonus;
    logic [1:0] GoalState;

    modport master (
        output frame_clk, FlagX, FlagY, FlagWidth, FlagHeight,
               PlayerX, PlayerY, PlayerS, Level_Ack,
        input  FlagDropY, Freeze, Level_Done, Bonus, GoalState
    );

    modport slave (
        input  frame_clk, FlagX, FlagY, FlagWidth, FlagHeight,
               PlayerX, PlayerY, PlayerS, Level_Ack,
        output FlagDropY, Freeze, Level_Done, Bonus, GoalState
    );
endinterface

// File: rtl/flag_goal.sv
// End-of-level goal sequencer: player/flag contact, cloth slide, hold, level-done handshake.
// Optional height bonus is built only when FLAG_BONUS_EN is defined.
module flag_goal #(
    parameter int SLIDE_STEP  = 2,
    parameter int HOLD_FRAMES = 120
) (
    input logic        Clk,
    input logic        Reset_n,
    flag_goal_if.slave bus
);

    localparam int CNT_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_FRAMES - 1);
    localparam logic [10:0]      STEP_11   = 11'(SLIDE_STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SLIDE = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } goal_state_t;

    function automatic logic [10:0] sat_sub(input logic [10:0] a, input logic [10:0] b);
        return (a > b) ? (a - b) : 11'd0;
    endfunction

    function automatic logic [10:0] add_11(input logic [9:0] a, input logic [10:0] b);
        return {1'b0, a} + b;
    endfunction

    // The cloth row is a 10-bit screen coordinate, so the landing row cannot exceed 1023.
    function automatic logic [10:0] clamp_row(input logic [10:0] row);
        return (row > 11'd1023) ? 11'd1023 : row;
    endfunction

`ifdef FLAG_BONUS_EN
    function automatic logic [3:0] bonus_sat(input logic [10:0] fb, input logic [9:0] py);
        logic [11:0] lim;
        logic [11:0] diff;
        lim = {1'b0, fb} + 12'd1;
        if ({2'b00, py} > lim) return 4'd0;
        diff = (lim - {2'b00, py}) >> 3;
        return (diff > 12'd15) ? 4'd15 : diff[3:0];
    endfunction
`endif

    goal_state_t       state_q, state_nx;
    logic [9:0]        drop_q, drop_nx;
    logic [CNT_W-1:0]  cnt_q, cnt_nx;
    logic              freeze_q, done_q;
    logic              frame_clk_d;
    logic [10:0]       step_p0;

    // Stage p0: live geometry and frame tick, all combinational from current inputs
    logic [10:0] half_w_p0, half_h_p0;
    logic [10:0] fl_p0, fr_p0, ft_p0, fb_p0, fb_row_p0;
    logic [10:0] pl_p0, pr_p0, pt_p0, pb_p0;
    logic        overlap_p0, tick_p0;

    assign half_w_p0  = {1'b0, bus.FlagWidth}  >> 1;
    assign half_h_p0  = {1'b0, bus.FlagHeight} >> 1;
    assign fl_p0      = sat_sub({1'b0, bus.FlagX}, half_w_p0);
    assign fr_p0      = sat_sub(add_11(bus.FlagX, half_w_p0), 11'd1);
    assign ft_p0      = sat_sub({1'b0, bus.FlagY}, half_h_p0);
    assign fb_p0      = sat_sub(add_11(bus.FlagY, half_h_p0), 11'd1);
    assign fb_row_p0  = clamp_row(fb_p0);
    assign pl_p0      = sat_sub({1'b0, bus.PlayerX}, {1'b0, bus.PlayerS});
    assign pr_p0      = add_11(bus.PlayerX, {1'b0, bus.PlayerS});
    assign pt_p0      = sat_sub({1'b0, bus.PlayerY}, {1'b0, bus.PlayerS});
    assign pb_p0      = add_11(bus.PlayerY, {1'b0, bus.PlayerS});
    assign overlap_p0 = (pl_p0 <= fr_p0) && (pr_p0 >= fl_p0) &&
                        (pt_p0 <= fb_p0) && (pb_p0 >= ft_p0);
    assign tick_p0    = bus.frame_clk & ~frame_clk_d;
    assign step_p0    = {1'b0, drop_q} + STEP_11;

`ifdef FLAG_BONUS_EN
    logic [3:0] bonus_q, bonus_nx;
`endif

    always_comb begin
        state_nx = state_q;
        drop_nx  = drop_q;
        cnt_nx   = cnt_q;
`ifdef FLAG_BONUS_EN
        bonus_nx = bonus_q;
`endif
        case (state_q)
            IDLE: begin
                drop_nx = ft_p0[9:0];
                if (tick_p0 && overlap_p0) begin
                    state_nx = SLIDE;
`ifdef FLAG_BONUS_EN
                    bonus_nx = bonus_sat(fb_p0, bus.PlayerY);
`endif
                end
            end
            SLIDE: begin
                if (tick_p0) begin
                    if (step_p0 >= fb_row_p0) begin
                        drop_nx  = fb_row_p0[9:0];
                        state_nx = HOLD;
                        cnt_nx   = HOLD_LOAD;
                    end else begin
                        drop_nx = step_p0[9:0];
                    end
                end
            end
            HOLD: begin
                if (tick_p0) begin
                    if (cnt_q == '0) state_nx = DONE;
                    else             cnt_nx   = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (bus.Level_Ack) begin
                    state_nx = IDLE;
                    drop_nx  = ft_p0[9:0];
`ifdef FLAG_BONUS_EN
                    bonus_nx = 4'd0;
`endif
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Stage p1: registered state and outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            drop_q      <= 10'd0;
            cnt_q       <= '0;
            freeze_q    <= 1'b0;
            done_q      <= 1'b0;
            frame_clk_d <= 1'b1;
        end else begin
            state_q     <= state_nx;
            drop_q      <= drop_nx;
            cnt_q       <= cnt_nx;
            freeze_q    <= (state_nx != IDLE);
            done_q      <= (state_nx == DONE);
            frame_clk_d <= bus.frame_clk;
        end
    end

`ifdef FLAG_BONUS_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) bonus_q <= 4'd0;
        else          bonus_q <= bonus_nx;
    end
    assign bus.Bonus = bonus_q;
`else
    assign bus.Bonus = 4'd0;
`endif

    assign bus.FlagDropY  = drop_q;
    assign bus.Freeze     = freeze_q;
    assign bus.Level_Done = done_q;
    assign bus.GoalState  = state_q;

endmodule

// File: doc/flag_goal.md
# flag_goal

- Consumes the flag stage's position/size outputs plus the player sprite's position once per frame.
- Detects the player touching the goal flag, then runs the end-of-level sequence:
  - freezes the player,
  - animates the flag cloth sliding down the pole,
  - holds a celebration delay,
  - raises level-complete until the game controller acknowledges.
- Sits between the flag stage and the color mapper / game-state controller.

## Interface
Parameters:
- SLIDE_STEP, 2 — pixels the cloth drops per frame tick.
- HOLD_FRAMES, 120 — frame ticks spent in HOLD after the cloth lands.

Ports:
- Clk  in  1  system clock; all state changes on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_clk  in  1  vertical-sync-rate strobe, synchronous to Clk; its rising edge defines a frame tick.
- FlagX, FlagY  in  10  flag centre.
- FlagWidth, FlagHeight  in  10  full flag extent.
- PlayerX, PlayerY  in  10  player centre.
- PlayerS  in  10  player half-size.
- Level_Ack  in  1  game controller acknowledge; level-sensitive.
- FlagDropY  out  10  current top row of the flag cloth.
- Freeze  out  1  player motion disable.
- Level_Done  out  1  level complete; held until acknowledged.
- Bonus  out  4  height bonus latched at contact.
- GoalState  out  2  IDLE=0, SLIDE=1, HOLD=2, DONE=3.

## Operation
Frame tick:
- tick = frame_clk & ~frame_clk_d, where frame_clk_d is a Clk register.
- frame_clk_d resets to 1, so a high frame_clk at reset release gives no tick.

Geometry (11-bit unsigned internal arithmetic; lower bounds saturate at 0):
- fl = FlagX − FlagWidth/2, fr = FlagX + FlagWidth/2 − 1.
- ft = FlagY − FlagHeight/2, fb = FlagY + FlagHeight/2 − 1.
- Player box is [PlayerX±PlayerS] × [PlayerY±PlayerS], inclusive.
- Overlap iff pl ≤ fr, pr ≥ fl, pt ≤ fb and pb ≥ ft.
- Geometry is recomputed live every cycle.

FSM (transitions evaluated only on tick, except DONE exit):
- IDLE:
  - FlagDropY tracks ft every cycle.
  - On tick with overlap: → SLIDE, latch Bonus = min(15, (fb + 1 − PlayerY) >> 3).
  - If PlayerY > fb + 1, Bonus = 0.
- SLIDE: on tick, FlagDropY = min(FlagDropY + SLIDE_STEP, fb). On reaching fb in that update: → HOLD, load HoldCnt = HOLD_FRAMES − 1.
- HOLD: on tick, if HoldCnt == 0 → DONE, else decrement.
- DONE: Level_Done = 1. Level_Ack high on any Clk edge → IDLE, Bonus cleared.

Outputs and boundary rules:
- Freeze = 1 in SLIDE, HOLD and DONE.
- Overlap is ignored outside IDLE.
- Level_Ack is ignored outside DONE.
- If Level_Ack is still high on return to IDLE, it has no effect.
- If the flag moves mid-SLIDE so that fb < FlagDropY, the next tick clamps FlagDropY to fb and transitions to HOLD.
- HOLD_FRAMES = 1: exactly one tick in HOLD.
- Reset asserted mid-sequence: immediate return to IDLE with reset values.

## Timing
Reset values:
- GoalState = IDLE, Freeze = 0, Level_Done = 0, Bonus = 0, HoldCnt = 0.
- FlagDropY = 0; it tracks ft from the first cycle after reset release.

Latency:
- All outputs are registered.
- The tick is detected in the Clk cycle where frame_clk is first sampled high.
- State and outputs update on that same Clk edge, one cycle after frame_clk rises at the Clk input.
- Level_Done falls on the first Clk edge at which Level_Ack = 1 is sampled.

Throughput: at most one FSM step per frame tick; frame_clk must stay low at least one Clk between ticks.

## Configuration
FLAG_BONUS_EN:
- Defined: Bonus is computed and latched as above.
- Undefined: Bonus is tied to 0 and its subtract/shift/saturate logic is removed; all other behaviour is unchanged.

## Test plan
Common setup unless stated: FlagX = 575, FlagY = 245, FlagWidth = 44, FlagHeight = 40 (fl = 553, fr = 596, ft = 225, fb = 264).

1. Player (540,245), S = 8, 10 ticks → GoalState = IDLE, FlagDropY = 225, Freeze = 0.
2. Player (560,230), S = 8, one tick:
   - GoalState = SLIDE, Freeze = 1.
   - Bonus = 4 with FLAG_BONUS_EN defined, 0 without.
3. Continue from 2:
   - FlagDropY = 227, 229, … 263, then 264 on the 20th SLIDE tick with → HOLD.
   - DONE entered after 120 further ticks; Level_Done = 1.
4. In DONE:
   - No Level_Ack for 5 ticks → Level_Done stays 1.
   - Pulse Level_Ack for one Clk → IDLE next edge, Level_Done = 0, Bonus = 0, FlagDropY = 225.
5. Assert Reset_n = 0 mid-HOLD, asynchronously between Clk edges → all outputs at reset values immediately, GoalState = 0.
6. Hold frame_clk high through reset release → no tick. Player (575,150), S = 8 (no overlap), then move to (575,226) → SLIDE with Bonus = min(15, 39 >> 3) = 4.
